// File: rtl/bitmap_bbox_scan_if.sv
// ---------------------------------------------------------------------------
// bitmap_bbox_scan_if
//   Bundles the request and result signals of bitmap_bbox_scan.
//
//   Handshake: a request is accepted on the rising edge where start=1 and
//   busy=0 (the scanner is idle). start while busy=1 is dropped and never
//   queued. bitmap/min_px only have to be stable on the accepting edge.
//   The results are valid from the cycle where done=1 (a single-cycle
//   pulse). They then hold until the next scan completes.
//
//   Signals:
//     start      request a scan (master -> slave)
//     bitmap     ROWS*COLS bits; row r = bitmap[r*COLS +: COLS], row 0 at
//                the bottom, column 0 (left) = bit COLS-1 of each row
//     min_px     occupancy threshold (a value of 0 is treated as 1)
//     busy       scan in progress
//     done       one-cycle result-valid pulse
//     bottom_gap / top_gap   unoccupied rows at the bottom / top
//     left_gap / right_gap   empty columns at the left / right
//     empty      no occupied row
//     dbg_state  current scanner state, for observation only
// ---------------------------------------------------------------------------
interface bitmap_bbox_scan_if #(
  parameter int ROWS  = 64,
  parameter int COLS  = 24,
  parameter int ROW_W = $clog2(ROWS + 1),
  parameter int COL_W = $clog2(COLS + 1)
);
  logic                   start;
  logic [ROWS*COLS-1:0]   bitmap;
  logic [COL_W-1:0]       min_px;
  logic                   busy;
  logic                   done;
  logic [ROW_W-1:0]       bottom_gap;
  logic [ROW_W-1:0]       top_gap;
  logic [COL_W-1:0]       left_gap;
  logic [COL_W-1:0]       right_gap;
  logic                   empty;
  logic [1:0]             dbg_state;

  modport master (
    output start, bitmap, min_px,
    input  busy, done, bottom_gap, top_gap, left_gap, right_gap, empty,
           dbg_state
  );

  modport slave (
    input  start, bitmap, min_px,
    output busy, done, bottom_gap, top_gap, left_gap, right_gap, empty,
           dbg_state
  );
endinterface

// File: rtl/bitmap_bbox_scan.sv
// ---------------------------------------------------------------------------
// bitmap_bbox_scan
//   Scans a ROWS x COLS glyph bitmap LANES rows per clock and reports the
//   empty margins on all four sides plus an all-empty flag. A row takes
//   part only if its set-pixel count reaches max(min_px,1), which keeps
//   sparse noise rows out of the bounding box.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; aborts a scan without a done
//     bus    bitmap_bbox_scan_if.slave (start/bitmap/min_px in,
//            busy/done/gap results/empty/dbg_state out)
//
//   Timing: start is accepted on edge E0. Groups 0..N-1 (N = ROWS/LANES)
//   are consumed on edges E0+1..E0+N. The results are registered and done
//   pulses on edge E0+N+1.
// ---------------------------------------------------------------------------
module bitmap_bbox_scan #(
  parameter int ROWS  = 64,
  parameter int COLS  = 24,
  parameter int LANES = 1,
  parameter int ROW_W = $clog2(ROWS + 1),
  parameter int COL_W = $clog2(COLS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  bitmap_bbox_scan_if.slave bus
);

  localparam int NGRP  = ROWS / LANES;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Control
  logic [1:0]       state_q, state_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Latched request
  logic [COLS-1:0]  rows_q [ROWS];
  logic [COLS-1:0]  rows_d [ROWS];
  logic [COL_W-1:0] thr_q, thr_d;

  // Accumulators
  logic             found_q, found_d;
  logic [ROW_W-1:0] first_q, first_d;
  logic [ROW_W-1:0] last_q, last_d;
  logic [COLS-1:0]  col_or_q, col_or_d;

  // Results
  logic [ROW_W-1:0] bottom_q, bottom_d;
  logic [ROW_W-1:0] top_q, top_d;
  logic [COL_W-1:0] left_q, left_d;
  logic [COL_W-1:0] right_q, right_d;
  logic             empty_q, empty_d;

  // Leading/trailing zero counts of the accumulated column OR.
  logic [COL_W-1:0] lz, tz;

  always_comb begin
    logic hit_l;
    logic hit_t;
    lz    = COL_W'(COLS);
    tz    = COL_W'(COLS);
    hit_l = 1'b0;
    hit_t = 1'b0;
    for (int i = 0; i < COLS; i++) begin
      if (!hit_l && col_or_q[COLS-1-i]) begin
        lz    = COL_W'(i);
        hit_l = 1'b1;
      end
      if (!hit_t && col_or_q[i]) begin
        tz    = COL_W'(i);
        hit_t = 1'b1;
      end
    end
  end

  always_comb begin
    logic [ROW_W-1:0] r_idx;
    logic [COLS-1:0]  row_v;
    logic [COL_W-1:0] pop;

    state_d  = state_q;
    grp_d    = grp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rows_d   = rows_q;
    thr_d    = thr_q;
    found_d  = found_q;
    first_d  = first_q;
    last_d   = last_q;
    col_or_d = col_or_q;
    bottom_d = bottom_q;
    top_d    = top_q;
    left_d   = left_q;
    right_d  = right_q;
    empty_d  = empty_q;
    r_idx    = '0;
    row_v    = '0;
    pop      = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SCAN;
          busy_d  = 1'b1;
          grp_d   = '0;
          for (int r = 0; r < ROWS; r++) begin
            rows_d[r] = bus.bitmap[r*COLS +: COLS];
          end
          // A threshold of 0 would mark blank rows occupied; clamp to 1.
          thr_d    = (bus.min_px == '0) ? COL_W'(1) : bus.min_px;
          found_d  = 1'b0;
          first_d  = '0;
          last_d   = '0;
          col_or_d = '0;
        end
      end

      ST_SCAN: begin
        // Lanes are walked in ascending row order so that first_d picks
        // the lowest occupied row and last_d the highest one in the group.
        for (int l = 0; l < LANES; l++) begin
          r_idx = ROW_W'(grp_q) * ROW_W'(LANES) + ROW_W'(l);
          row_v = rows_q[r_idx[IDX_W-1:0]];
          pop   = '0;
          for (int c = 0; c < COLS; c++) begin
            pop = pop + COL_W'(row_v[c]);
          end
          if (pop >= thr_q) begin
            if (!found_d) begin
              first_d = r_idx;
            end
            found_d  = 1'b1;
            last_d   = r_idx;
            col_or_d = col_or_d | row_v;
          end
        end
        if (grp_q == GRP_W'(NGRP - 1)) begin
          state_d = ST_FINISH;
        end else begin
          grp_d = grp_q + GRP_W'(1);
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (found_q) begin
          bottom_d = first_q;
          top_d    = ROW_W'(ROWS - 1) - last_q;
          left_d   = lz;
          right_d  = tz;
          empty_d  = 1'b0;
        end else begin
          bottom_d = ROW_W'(ROWS);
          top_d    = ROW_W'(ROWS);
          left_d   = COL_W'(COLS);
          right_d  = COL_W'(COLS);
          empty_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grp_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rows_q   <= '{default: '0};
      thr_q    <= '0;
      found_q  <= 1'b0;
      first_q  <= '0;
      last_q   <= '0;
      col_or_q <= '0;
      bottom_q <= '0;
      top_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rows_q   <= rows_d;
      thr_q    <= thr_d;
      found_q  <= found_d;
      first_q  <= first_d;
      last_q   <= last_d;
      col_or_q <= col_or_d;
      bottom_q <= bottom_d;
      top_q    <= top_d;
      left_q   <= left_d;
      right_q  <= right_d;
      empty_q  <= empty_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bottom_gap = bottom_q;
  assign bus.top_gap    = top_q;
  assign bus.left_gap   = left_q;
  assign bus.right_gap  = right_q;
  assign bus.empty      = empty_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_bitmap_bbox_scan.sv
module tb_bitmap_bbox_scan;
  localparam int ROWS  = 64;
  localparam int COLS  = 24;
  localparam int ROW_W = 7;
  localparam int COL_W = 5;
  localparam int BW    = ROWS * COLS;

  typedef struct packed {
    logic [ROW_W-1:0] bottom;
    logic [ROW_W-1:0] top;
    logic [COL_W-1:0] left;
    logic [COL_W-1:0] right;
    logic             empty;
  } res_t;

  typedef struct {
    logic [BW-1:0]    bm;
    logic [COL_W-1:0] mp;
    res_t             exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitmap_bbox_scan_if #(.ROWS(ROWS), .COLS(COLS)) if1 ();
  bitmap_bbox_scan_if #(.ROWS(ROWS), .COLS(COLS)) if4 ();

  bitmap_bbox_scan #(.ROWS(ROWS), .COLS(COLS), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  bitmap_bbox_scan #(.ROWS(ROWS), .COLS(COLS), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t act, input res_t exp);
    check({tag, ".bottom_gap"}, 32'(act.bottom), 32'(exp.bottom));
    check({tag, ".top_gap"},    32'(act.top),    32'(exp.top));
    check({tag, ".left_gap"},   32'(act.left),   32'(exp.left));
    check({tag, ".right_gap"},  32'(act.right),  32'(exp.right));
    check({tag, ".empty"},      32'(act.empty),  32'(exp.empty));
  endtask

  function automatic res_t mk(input int b, input int t, input int l, input int r, input bit e);
    res_t x;
    x.bottom = ROW_W'(b);
    x.top    = ROW_W'(t);
    x.left   = COL_W'(l);
    x.right  = COL_W'(r);
    x.empty  = e;
    return x;
  endfunction

  // Reference: collect the occupied rows, take their extent and the
  // column span of their union.
  function automatic res_t model(input logic [BW-1:0] bm, input logic [COL_W-1:0] mp);
    int thr;
    int lo;
    int hi;
    int k;
    int j;
    logic [COLS-1:0] row;
    logic [COLS-1:0] acc;
    thr = (mp == 0) ? 1 : int'(mp);
    lo  = -1;
    hi  = -1;
    acc = '0;
    for (int r = 0; r < ROWS; r++) begin
      row = bm[r*COLS +: COLS];
      if ($countones(row) >= thr) begin
        if (lo < 0) lo = r;
        hi  = r;
        acc = acc | row;
      end
    end
    if (lo < 0) return mk(ROWS, ROWS, COLS, COLS, 1'b1);
    k = 0;
    while (k < COLS && !acc[COLS-1-k]) k++;
    j = 0;
    while (j < COLS && !acc[j]) j++;
    return mk(lo, ROWS - 1 - hi, k, j, 1'b0);
  endfunction

  function automatic res_t read_res(input int sel);
    res_t x;
    if (sel == 1) begin
      x.bottom = if1.bottom_gap; x.top = if1.top_gap; x.left = if1.left_gap;
      x.right  = if1.right_gap;  x.empty = if1.empty;
    end else begin
      x.bottom = if4.bottom_gap; x.top = if4.top_gap; x.left = if4.left_gap;
      x.right  = if4.right_gap;  x.empty = if4.empty;
    end
    return x;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 1) ? if1.done : if4.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? if1.busy : if4.busy;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int sel, input logic st, input logic [BW-1:0] bm,
                       input logic [COL_W-1:0] mp);
    if (sel == 1) begin
      if1.start = st; if1.bitmap = bm; if1.min_px = mp;
    end else begin
      if4.start = st; if4.bitmap = bm; if4.min_px = mp;
    end
  endtask

  // Presents start for one edge, then counts edges until done. align=0
  // means the caller is already just after an edge (back-to-back start).
  task automatic run_scan(input int sel, input string tag, input logic [BW-1:0] bm,
                          input logic [COL_W-1:0] mp, input res_t exp,
                          input int exp_edges, input bit align, input bit post);
    int edges;
    int busy_low;
    bit seen;
    edges    = 0;
    busy_low = 0;
    seen     = 1'b0;
    if (align) @(negedge clk);
    drive(sel, 1'b1, bm, mp);
    while (!seen && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) drive(sel, 1'b0, bm, mp);
      if (get_done(sel)) seen = 1'b1;
      else if (!get_busy(sel)) busy_low++;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(edges), 32'(exp_edges));
    check({tag, ".busy_during_scan"}, 32'(busy_low), 32'd0);
    check({tag, ".busy_at_done"}, 32'(get_busy(sel)), 32'd0);
    check_res(tag, read_res(sel), exp);
    if (post) begin
      @(posedge clk);
      #1;
      check({tag, ".done_single"}, 32'(get_done(sel)), 32'd0);
      check_res({tag, ".hold"}, read_res(sel), exp);
    end
  endtask

  function automatic logic [BW-1:0] tp1_bitmap();
    logic [BW-1:0] bm;
    bm = '0;
    for (int r = 60; r <= 63; r++) bm[r*COLS +: COLS] = 24'h3fffff;
    for (int r = 2; r <= 29; r++)  bm[r*COLS +: COLS] = 24'h3f0000;
    return bm;
  endfunction

  function automatic logic [BW-1:0] pixel(input int r, input int bit_pos);
    logic [BW-1:0] bm;
    bm = '0;
    bm[r*COLS + bit_pos] = 1'b1;
    return bm;
  endfunction

  vec_t vecs[10];

  // ---------------- main sequence ----------------
  initial begin
    logic [BW-1:0] bm_a;
    logic [BW-1:0] bm_b;
    logic [BW-1:0] bm_r;
    logic [COL_W-1:0] mp_r;
    int n_done;
    int done_edge;
    int busy_low;
    int sel;

    bm_a = tp1_bitmap();
    vecs[0] = '{bm_a,          5'd1,  mk(2, 0, 2, 0, 1'b0)};
    vecs[1] = '{bm_a,          5'd7,  mk(60, 0, 2, 0, 1'b0)};
    vecs[2] = '{'0,            5'd1,  mk(64, 64, 24, 24, 1'b1)};
    vecs[3] = '{bm_a,          5'd0,  mk(2, 0, 2, 0, 1'b0)};
    vecs[4] = '{bm_a,          5'd22, mk(60, 0, 2, 0, 1'b0)};
    vecs[5] = '{bm_a,          5'd23, mk(64, 64, 24, 24, 1'b1)};
    vecs[6] = '{bm_a,          5'd25, mk(64, 64, 24, 24, 1'b1)};
    vecs[7] = '{pixel(0, 0),   5'd1,  mk(0, 63, 23, 0, 1'b0)};
    vecs[8] = '{pixel(37, 13), 5'd1,  mk(37, 26, 10, 13, 1'b0)};
    vecs[9] = '{pixel(63, 23), 5'd1,  mk(63, 0, 0, 23, 1'b0)};

    drive(1, 1'b0, '0, '0);
    drive(4, 1'b0, '0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(if1.busy), 32'd0);
    check("reset.done", 32'(if1.done), 32'd0);
    check("reset.state", 32'(if1.dbg_state), 32'd0);
    check_res("reset.l1", read_res(1), mk(0, 0, 0, 0, 1'b0));
    check_res("reset.l4", read_res(4), mk(0, 0, 0, 0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors on both lane configurations
    for (int i = 0; i < 10; i++) begin
      run_scan(1, $sformatf("vec%0d.l1", i), vecs[i].bm, vecs[i].mp, vecs[i].exp, 66, 1'b1, 1'b1);
      run_scan(4, $sformatf("vec%0d.l4", i), vecs[i].bm, vecs[i].mp, vecs[i].exp, 18, 1'b1, 1'b1);
    end

    // Back-to-back: start held high in the done cycle is accepted
    run_scan(1, "b2b.first", bm_a, 5'd1, mk(2, 0, 2, 0, 1'b0), 66, 1'b1, 1'b0);
    run_scan(1, "b2b.second", '0, 5'd1, mk(64, 64, 24, 24, 1'b1), 66, 1'b0, 1'b1);

    // Randomized scans against the reference model
    for (int i = 0; i < 24; i++) begin
      bm_r = '0;
      for (int r = 0; r < ROWS; r++) begin
        case ($urandom_range(0, 4))
          0, 1:    bm_r[r*COLS +: COLS] = '0;
          2:       bm_r[r*COLS +: COLS] = COLS'($urandom);
          3:       bm_r[r*COLS +: COLS] = COLS'($urandom & $urandom & $urandom);
          default: bm_r[r*COLS + $urandom_range(0, COLS-1)] = 1'b1;
        endcase
      end
      mp_r = ($urandom_range(0, 5) == 0) ? COL_W'($urandom_range(0, 31))
                                         : COL_W'($urandom_range(0, 8));
      sel  = (i % 2 == 0) ? 1 : 4;
      run_scan(sel, $sformatf("rand%0d", i), bm_r, mp_r, model(bm_r, mp_r),
               (sel == 1) ? 66 : 18, 1'b1, 1'b0);
    end

    // Mid-scan start and bitmap change are ignored
    bm_b = '1;
    n_done    = 0;
    done_edge = 0;
    busy_low  = 0;
    @(negedge clk);
    drive(1, 1'b1, bm_a, 5'd1);
    for (int e = 1; e <= 150; e++) begin
      @(posedge clk);
      #1;
      if (e == 1)  drive(1, 1'b0, bm_a, 5'd1);
      if (e == 10) drive(1, 1'b1, bm_b, 5'd3);
      if (e == 11) drive(1, 1'b0, bm_b, 5'd3);
      if (if1.done) begin
        n_done++;
        if (done_edge == 0) done_edge = e;
      end else if (done_edge == 0 && !if1.busy) begin
        busy_low++;
      end
    end
    check("midscan.done_count", 32'(n_done), 32'd1);
    check("midscan.latency", 32'(done_edge), 32'd66);
    check("midscan.busy_held", 32'(busy_low), 32'd0);
    check_res("midscan", read_res(1), mk(2, 0, 2, 0, 1'b0));

    // Reset at scan cycle 20 aborts the scan
    @(negedge clk);
    drive(1, 1'b1, pixel(5, 5), 5'd1);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) drive(1, 1'b0, pixel(5, 5), 5'd1);
    end
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(if1.busy), 32'd0);
    check("abort.done", 32'(if1.done), 32'd0);
    check("abort.state", 32'(if1.dbg_state), 32'd0);
    check_res("abort", read_res(1), mk(0, 0, 0, 0, 1'b0));
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int e = 0; e < 80; e++) begin
      @(posedge clk);
      #1;
      if (if1.done) n_done++;
    end
    check("abort.no_done", 32'(n_done), 32'd0);
    run_scan(1, "after_abort", pixel(5, 5), 5'd1, mk(5, 58, 18, 5, 1'b0), 66, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bitmap_bbox_scan.md
Name: bitmap_bbox_scan

Overview:
- Parametrised successor to the fixed 64x24 compare/accumulate block.
- Takes a ROWS x COLS glyph bitmap, scans it LANES rows per cycle and reports the empty margins on all four sides (bottom, top, left, right) plus an all-empty flag.
- A row counts as occupied only when its set-pixel count reaches a programmable threshold, so sparse noise rows can be ignored.
- Sits between the glyph framebuffer and the template-match stage; it supplies the alignment offsets for template matching.

Parameters:
- ROWS, 64, bitmap rows.
- COLS, 24, bitmap columns.
- LANES, 1, rows processed per scan cycle; must divide ROWS.
- ROW_W, $clog2(ROWS+1), width of row-count outputs.
- COL_W, $clog2(COLS+1), width of column-count outputs and min_px.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- bitmap  in  ROWS*COLS  row r = bitmap[r*COLS +: COLS]; row 0 = bottom; column 0 (left) = bit COLS-1 of each row.
- min_px  in  COL_W  occupancy threshold; a row is occupied if popcount >= max(min_px,1).
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- bottom_gap  out  ROW_W  count of unoccupied rows starting at row 0.
- top_gap  out  ROW_W  count of unoccupied rows starting at row ROWS-1.
- left_gap  out  COL_W  leading zero columns of the OR of occupied rows, counted from column 0.
- right_gap  out  COL_W  trailing zero columns of the same OR.
- empty  out  1  no occupied row.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; internal registers cleared.
  - Reset mid-scan aborts the scan with no done pulse.
- States:
  - IDLE -> SCAN on start=1: latch bitmap and min_px, clear accumulators, set busy=1.
  - SCAN: one edge per row group g = 0..N-1 (N=ROWS/LANES); rows g*LANES .. g*LANES+LANES-1 are evaluated in ascending order.
  - SCAN, after group N-1 -> FINISH.
  - FINISH -> IDLE: register the gap outputs and empty, pulse done=1, clear busy.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+N+1, i.e. N+2 edges after start was presented. Default config: 66 edges (LANES=1), 34 (LANES=2).
- Accumulators, updated per occupied row r:
  - first_occ <= r if none is seen yet.
  - last_occ <= r.
  - col_or |= row r.
  - Unoccupied rows contribute nothing, including to col_or.
- Results:
  - bottom_gap = first_occ.
  - top_gap = ROWS-1-last_occ.
  - left_gap = leading zeros of col_or from bit COLS-1.
  - right_gap = trailing zeros from bit 0.
- Empty case: empty=1, bottom_gap=top_gap=ROWS, left_gap=right_gap=COLS.
- Output hold: results hold their values until the next FINISH; they are not cleared at start.
- Input changes: start while busy is ignored, with no queuing. bitmap and min_px changes after E0 have no effect on the current scan.
- Back-to-back: start high in the done cycle is accepted, since the state is IDLE that cycle.
- min_px > COLS: no row can be occupied, so the empty result is returned.

Test Plan:
1. Default params, min_px=1. Rows 63..60 = 0x3fffff; rows 29..2 = 0x3f0000; all other rows 0. -> done after 66 edges: bottom_gap=2, top_gap=0, left_gap=2, right_gap=0, empty=0.
2. Same bitmap, min_px=7. -> bottom_gap=60, top_gap=0, left_gap=2, right_gap=0.
3. All-zero bitmap. -> empty=1, bottom_gap=64, top_gap=64, left_gap=24, right_gap=24; done pulses exactly once.
4. LANES=4, single pixel at row 37, column 10 (bit 13). -> done 18 edges after start; bottom_gap=37, top_gap=26, left_gap=10, right_gap=13.
5. start pulsed again mid-scan and bitmap changed mid-scan. -> only one done; results match the originally latched bitmap; busy stays high throughout.
6. rst_n low at scan cycle 20. -> all outputs 0 immediately, no done; a following start produces correct results.
